// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the sequential carry-save multiplier front end.
package mult_pkg;
   localparam int N     = 16;
   localparam int W     = 2 * N;
   localparam int CNT_W = $clog2(N);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [W-1:0] word_t;
endpackage

// File: rtl/csa_3to2.sv
// One carry-save compression step: folds a partial product into the (sum, carry) pair.
module csa_3to2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] c,
   input  logic [W-1:0] p,
   output logic [W-1:0] s_n,
   output logic [W-1:0] c_n
);
   logic [W-1:0] maj;

   assign s_n = s ^ c ^ p;
   assign maj = (s & c) | (s & p) | (c & p);
   // Dropping the carry MSB keeps (s_n + c_n) correct modulo 2^W.
   assign c_n = {maj[W-2:0], 1'b0};
endmodule

// File: rtl/csa_mult_front.sv
// Sequential carry-save multiplier front end feeding a 2N-bit CPA with x/y.
// Optional build macro SKIP_ZERO_EN: terminate accumulation once no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ACCUM | adding one shifted partial product per cycle
// DONE  | x/y hold the result, waiting for out_ready
module csa_mult_front
   import mult_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x,
   output logic [W-1:0] y
);
   state_t           state_r, state_nx;
   logic [CNT_W-1:0] cnt_r;
   logic [N-1:0]     a_r, b_r;
   word_t            s_r, c_r;
   word_t            pp, s_n, c_n, a_ext;
   logic             accept;

   assign accept = (state_r == IDLE) && in_valid;
   assign a_ext  = {{N{1'b0}}, a_r};
   assign pp     = b_r[0] ? (a_ext << cnt_r) : '0;

   csa_3to2 #(.W(W)) u_csa (
      .s   (s_r),
      .c   (c_r),
      .p   (pp),
      .s_n (s_n),
      .c_n (c_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
`ifdef SKIP_ZERO_EN
               state_nx = (b == '0) ? DONE : ACCUM;
`else
               state_nx = ACCUM;
`endif
            end
         end
         ACCUM: begin
`ifdef SKIP_ZERO_EN
            if ((cnt_r == CNT_LAST) || (b_r[N-1:1] == '0)) state_nx = DONE;
`else
            if (cnt_r == CNT_LAST) state_nx = DONE;
`endif
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_r == IDLE);
      out_valid = (state_r == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
         a_r   <= '0;
         b_r   <= '0;
         s_r   <= '0;
         c_r   <= '0;
      end else if (accept) begin
         cnt_r <= '0;
         a_r   <= a;
         b_r   <= b;
         s_r   <= '0;
         c_r   <= '0;
      end else if (state_r == ACCUM) begin
         s_r   <= s_n;
         c_r   <= c_n;
         b_r   <= b_r >> 1;
         cnt_r <= cnt_r + 1'b1;
      end
   end

   assign x = s_r;
   assign y = c_r;
endmodule

// File: tb/tb_csa_mult_front.sv
// Directed and randomized checks of csa_mult_front (default build) with a CPA sum model.
module tb_csa_mult_front;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] x, y;

   int n_assert = 0;
   int n_fail   = 0;

   csa_mult_front dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x         (x),
      .y         (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [31:0] exp, input int stall, input string tag);
      int          cyc;
      logic [31:0] x0, y0;
      @(negedge clk);
      a = ta; b = tb_v; in_valid = 1'b1;
      check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'd16);
      check({tag, " sum"}, x + y, exp);
      x0 = x; y0 = y;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         @(negedge clk);
         check({tag, " stall_x"}, x, x0);
         check({tag, " stall_y"}, y, y0);
         check({tag, " stall_valid"}, 32'(out_valid), 32'd1);
         check({tag, " stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " valid_after_hs"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
      check({tag, " idle_hold"}, x + y, exp);
   endtask

   initial begin
      logic [15:0] ra, rb;
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset x", x, 32'd0);
      check("reset y", y, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Abort a 12*71 operation mid-accumulation.
      @(negedge clk);
      a = 16'd12; b = 16'd71; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_abort out_valid", 32'(out_valid), 32'd0);
      check("pre_abort in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort x", x, 32'd0);
      check("abort y", y, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(16'd12, 16'd71, 32'd852, 0, "after_abort");

      do_op(16'd1,  16'd1,  32'd1,   0, "1x1");
      do_op(16'd2,  16'd2,  32'd4,   0, "2x2");
      do_op(16'd4,  16'd1,  32'd4,   0, "4x1");
      do_op(16'd12, 16'd71, 32'd852, 0, "12x71");
      do_op(16'd62, 16'd12, 32'd744, 0, "62x12");
      do_op(16'd5,  16'd16, 32'd80,  0, "5x16");
      do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, "max");
      do_op(16'd0,  16'd0,  32'd0,   0, "zero");
      do_op(16'd3,  16'h8000, 32'h00018000, 0, "3x8000");
      do_op(16'd300, 16'd7, 32'd2100, 10, "backpressure");

      for (int k = 0; k < 100; k++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         do_op(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
